// File: rtl/barrett_poly_sequencer_if.sv
// Control, coefficient-RAM and Barrett-unit signals seen by barrett_poly_sequencer.
// The master modport is the sequencer's view of these signals; the slave modport is its environment's view.
interface barrett_poly_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start_i;
  logic              abort_i;
  logic [ADDR_W-1:0] src_base_i;
  logic [ADDR_W-1:0] dst_base_i;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [ADDR_W-1:0] mem_raddr_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic [31:0]       mem_wdata_o;
  logic              bfu_valid_o;
  logic [31:0]       bfu_src_o;
  logic              bfu_flush_o;
  logic              bfu_valid_i;
  logic [31:0]       bfu_result_i;

  modport master (
    input  start_i, abort_i, src_base_i, dst_base_i,
    input  mem_gnt_i, mem_rdata_i, bfu_valid_i, bfu_result_i,
    output busy_o, done_o, aborted_o,
    output mem_req_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
    output bfu_valid_o, bfu_src_o, bfu_flush_o
  );

  modport slave (
    output start_i, abort_i, src_base_i, dst_base_i,
    output mem_gnt_i, mem_rdata_i, bfu_valid_i, bfu_result_i,
    input  busy_o, done_o, aborted_o,
    input  mem_req_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
    input  bfu_valid_o, bfu_src_o, bfu_flush_o
  );
endinterface

// File: rtl/barrett_poly_sequencer.sv
// Streams one polynomial from coefficient RAM through bfu_barrett and writes the reduced
// words back, with abort (flush + drain) and done signalling.
module barrett_poly_sequencer #(
  parameter int unsigned N_WORDS = 128,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned BFU_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  barrett_poly_sequencer_if.master   bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned AB_W   = $clog2(BFU_LAT + 2);
  localparam int unsigned AB_PEN = (BFU_LAT == 0) ? 0 : BFU_LAT - 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ABORT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [AB_W-1:0]   ab_cnt;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              req;
  logic              valid;
  logic              flush;

  logic active;
  logic rd_fire;
  logic wr_fire;

  assign active  = (state == RUN) || (state == DRAIN);
  assign rd_fire = req & bus.mem_gnt_i;
  assign wr_fire = active & bus.bfu_valid_i;

  // Outputs are registered except the data/address paths that must track the RAM and the unit.
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.aborted_o   = aborted;
  assign bus.mem_req_o   = req;
  assign bus.mem_raddr_o = src_base + rd_cnt[ADDR_W-1:0];
  assign bus.mem_we_o    = wr_fire;
  assign bus.mem_waddr_o = dst_base + wr_cnt[ADDR_W-1:0];
  assign bus.mem_wdata_o = bus.bfu_result_i;
  assign bus.bfu_valid_o = valid;
  assign bus.bfu_src_o   = bus.mem_rdata_i;
  assign bus.bfu_flush_o = flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      src_base <= '0;
      dst_base <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      ab_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      req      <= 1'b0;
      valid    <= 1'b0;
      flush    <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      valid   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            state    <= RUN;
            src_base <= bus.src_base_i;
            dst_base <= bus.dst_base_i;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            busy     <= 1'b1;
            req      <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (bus.abort_i) begin
            // A read granted in this cycle returns during ABORT and is dropped.
            state   <= ABORT;
            ab_cnt  <= '0;
            req     <= 1'b0;
            flush   <= 1'b1;
            aborted <= (BFU_LAT == 0);
          end else begin
            if (rd_fire) begin
              rd_cnt <= rd_cnt + CNT_W'(1);
              valid  <= 1'b1;
              if (rd_cnt == LAST_WORD) begin
                state <= DRAIN;
                req   <= 1'b0;
              end
            end
            if (wr_fire) begin
              wr_cnt <= wr_cnt + CNT_W'(1);
              if (wr_cnt == LAST_WORD) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ABORT: begin
          // Hold flush for BFU_LAT+1 cycles so every in-flight result is discarded.
          ab_cnt <= ab_cnt + AB_W'(1);
          if ((BFU_LAT != 0) && (ab_cnt == AB_W'(AB_PEN))) begin
            aborted <= 1'b1;
          end
          if (ab_cnt == AB_W'(BFU_LAT)) begin
            state <= IDLE;
            busy  <= 1'b0;
            flush <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          req   <= 1'b0;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_poly_sequencer.sv
// Scoreboard bench for barrett_poly_sequencer with a RAM model and a 1-cycle Barrett unit model.
module tb_barrett_poly_sequencer;

  localparam int unsigned N_WORDS = 128;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned BFU_LAT = 1;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrett_poly_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  barrett_poly_sequencer #(
    .N_WORDS(N_WORDS),
    .ADDR_W (ADDR_W),
    .BFU_LAT(BFU_LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int aborted_cnt = 0;
  logic gnt_rand = 1'b0;
  logic [31:0] ram [256];
  wr_t exp_q[$];
  wr_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient RAM: read data one cycle after req&gnt, write on we.
  always @(posedge clk) begin
    if (bus.mem_req_o && bus.mem_gnt_i) bus.mem_rdata_i <= ram[bus.mem_raddr_o];
    if (bus.mem_we_o) ram[bus.mem_waddr_o] <= bus.mem_wdata_o;
  end

  function automatic logic [15:0] red(input logic [15:0] x);
    return 16'(x % 16'd3329);
  endfunction

  // Barrett unit environment model, one cycle latency.
  always @(posedge clk) begin
    bus.bfu_valid_i  <= bus.bfu_valid_o;
    bus.bfu_result_i <= {red(bus.bfu_src_o[31:16]), red(bus.bfu_src_o[15:0])};
  end

  always @(negedge clk) bus.mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req_v);
    end
  endtask

  // Monitor: pops one expected write per DUT write, tracks done/aborted pulses.
  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.aborted_o === 1'b1) aborted_cnt++;
    if (bus.mem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, none required",
                 bus.mem_waddr_o, bus.mem_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_waddr_o), 32'(mon_e.addr));
        chk("wr_data", bus.mem_wdata_o, mon_e.data);
      end
    end
  end

  // Word k = {3329+k, k}; both halves reduce to k.
  task automatic init_ram();
    for (int k = 0; k < 256; k++)
      ram[k] = (k < 128) ? {16'(3329 + k), 16'(k)} : 32'h0;
  endtask

  task automatic push_exp(input int dst, input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = 8'(dst + k);
      e.data = {16'(k), 16'(k)};
      exp_q.push_back(e);
    end
  endtask

  task automatic start_pass(input logic [7:0] s, input logic [7:0] d);
    @(negedge clk);
    bus.src_base_i = s;
    bus.dst_base_i = d;
    bus.start_i    = 1'b1;
    start_cyc      = cyc;
    @(negedge clk);
    bus.start_i    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  int d0, a0;

  initial begin
    bus.start_i    = 1'b1;
    bus.abort_i    = 1'b0;
    bus.src_base_i = 8'h55;
    bus.dst_base_i = 8'h66;
    bus.bfu_valid_i = 1'b0;
    bus.bfu_result_i = '0;
    bus.mem_rdata_i = '0;
    init_ram();

    // Reset with start_i held high.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_aborted", 32'(bus.aborted_o), 32'd0);
    chk("rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_flush", 32'(bus.bfu_flush_o), 32'd0);
    chk("rst_bfu_valid", 32'(bus.bfu_valid_o), 32'd0);
    chk("rst_raddr", 32'(bus.mem_raddr_o), 32'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);

    // Full-grant in-place pass.
    push_exp(0, 128);
    d0 = done_cnt;
    start_pass(8'd0, 8'd0);
    chk("run_busy", 32'(bus.busy_o), 32'd1);
    chk("run_req", 32'(bus.mem_req_o), 32'd1);
    wait_done(400, d0);
    chk("done_latency", 32'(done_cyc - start_cyc), 32'd131);
    repeat (3) @(negedge clk);
    chk("pass1_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("pass1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("pass1_idle", 32'(bus.busy_o), 32'd0);

    // Random grant to second base, with an ignored start while busy.
    init_ram();
    gnt_rand = 1'b1;
    push_exp(128, 128);
    d0 = done_cnt;
    start_pass(8'd0, 8'd128);
    repeat (20) @(negedge clk);
    bus.src_base_i = 8'd3;
    bus.dst_base_i = 8'd5;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i    = 1'b0;
    wait_done(2000, d0);
    gnt_rand = 1'b0;
    repeat (5) @(negedge clk);
    chk("pass2_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("pass2_done_once", 32'(done_cnt - d0), 32'd1);

    // Abort at rd_cnt=40: words 0..38 written, word 39 result dropped.
    init_ram();
    push_exp(64, 39);
    d0 = done_cnt;
    a0 = aborted_cnt;
    start_pass(8'd0, 8'd64);
    repeat (40) @(negedge clk);
    chk("abort_raddr", 32'(bus.mem_raddr_o), 32'd40);
    chk("abort_flush_pre", 32'(bus.bfu_flush_o), 32'd0);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_flush1", 32'(bus.bfu_flush_o), 32'd1);
    chk("abort_req", 32'(bus.mem_req_o), 32'd0);
    chk("abort_we", 32'(bus.mem_we_o), 32'd0);
    chk("abort_bfu_valid", 32'(bus.bfu_valid_o), 32'd0);
    chk("abort_aborted_early", 32'(bus.aborted_o), 32'd0);
    @(negedge clk);
    chk("abort_flush2", 32'(bus.bfu_flush_o), 32'd1);
    chk("abort_pulse", 32'(bus.aborted_o), 32'd1);
    chk("abort_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    chk("abort_flush_end", 32'(bus.bfu_flush_o), 32'd0);
    chk("abort_idle", 32'(bus.busy_o), 32'd0);
    chk("abort_pulse_end", 32'(bus.aborted_o), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_once", 32'(aborted_cnt - a0), 32'd1);

    // start_i together with abort_i in IDLE is ignored.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk("start_abort_busy", 32'(bus.busy_o), 32'd0);
    chk("start_abort_req", 32'(bus.mem_req_o), 32'd0);
    repeat (4) @(negedge clk);

    // Reset during DRAIN: writes up to word 126 precede the reset edge.
    init_ram();
    push_exp(0, 127);
    d0 = done_cnt;
    start_pass(8'd0, 8'd0);
    repeat (128) @(negedge clk);
    chk("drain_req", 32'(bus.mem_req_o), 32'd0);
    chk("drain_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_drain_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_drain_we", 32'(bus.mem_we_o), 32'd0);
    repeat (5) @(negedge clk);
    chk("rst_drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rst_drain_no_done", 32'(done_cnt - d0), 32'd0);

    // Fresh pass after reset completes normally.
    init_ram();
    push_exp(0, 128);
    d0 = done_cnt;
    start_pass(8'd0, 8'd0);
    wait_done(400, d0);
    chk("fresh_done_latency", 32'(done_cyc - start_cyc), 32'd131);
    repeat (3) @(negedge clk);
    chk("fresh_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("fresh_idle", 32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
